aes_cipher_iter: RTL
====================

Name: aes_cipher_iter

Overview:
- Iterative AES encryption core: one cipher round per clock, replacing the fully unrolled combinational cipher where area matters.
- Takes one 128-bit plaintext block and the pre-expanded key schedule through a valid/ready handshake. Returns the ciphertext through a second valid/ready handshake.
- Supports AES-128/192/256 through NK.
- Reuses the existing SubBytes, ShiftRows, MixColumns and AddRoundKey datapath blocks; one instance of each.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8; other values are unsupported.
- NR, NK+6, number of rounds; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  plaintext and key schedule present.
- in_ready  out  1  core can accept a block.
- state_in  in  128  plaintext; state_in[127:120] = byte 0 (FIPS in0), state_in[7:0] = byte 15.
- w  in  128*(NR+1)  expanded key; w[r*128+:128] = round key r, same byte order as state_in.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- encrypted_msg  out  128  ciphertext, same byte order.
- busy  out  1  high while in ROUND state.

Behaviour:
- Reset (rst=1 at edge): FSM->IDLE, round counter=0, state register=0.
  - After reset: out_valid=0, encrypted_msg=0, busy=0, in_ready=1.
  - Reset overrides all other inputs and abandons any block in flight with no output.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - Accept on edge t when in_valid&&in_ready.
  - On accept: state_reg <= state_in ^ w[0+:128]; key_reg <= w (full schedule latched, so w may change after accept); rnd <= 1; ->ROUND.
- ROUND:
  - in_ready=0, busy=1.
  - Each edge, for rnd < NR: state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), key_reg[rnd]); rnd <= rnd+1.
  - At rnd == NR: final round without MixColumns; ->DONE.
- DONE:
  - out_valid=1, encrypted_msg=state_reg, in_ready=0.
  - Output held stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready edge: ->IDLE, out_valid=0.
  - No accept is possible in the same cycle, because in_ready=0 in DONE.
- Latency: accept at edge t, round k applied at edge t+k, out_valid high from edge t+NR.
  - NR cycles accept-to-valid: 10, 12 or 14.
  - Minimum issue interval NR+2 cycles with out_ready tied high.
- encrypted_msg holds the last ciphertext after the handshake until the next DONE. It is don't-care during ROUND only if ABORT is compiled in; otherwise it holds the last result.
  - Implementation: a separate 128-bit output register, loaded on entry to DONE.
- Round counter width is clog2(NR+1). The counter never wraps; it is cleared on accept.
- in_valid held high with changing data while in_ready=0: ignored, no effect.
- Simultaneous rst and handshake: rst wins.

Optional Feature:
- Macro: AES_CIPHER_ITER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge in ROUND or DONE: ->IDLE, out_valid=0, busy=0, in_ready=1 next cycle. encrypted_msg keeps its previous value.
  - abort in IDLE: ignored, and the accept still happens if in_valid=1.
  - rst has priority over abort.
- Not defined: no abort port; a block can only be terminated by rst.

Test Plan:
- FIPS-197 App. B, NK=4: state_in=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c expanded by the bench model, out_ready=1 -> out_valid exactly 10 cycles after accept, encrypted_msg=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C for all three key sizes, pt 00112233445566778899aabbccddeeff, key 000102..:
  - NK=4 -> 69c4e0d86a7b0430d8cdb78070b4c55a at 10 cycles.
  - NK=6 -> dda97ca4864cdfe06eaf70a0ec0d7191 at 12 cycles.
  - NK=8 -> 8ea2b7ca516745bfeafc49904b496089 at 14 cycles.
- Backpressure and key latching, NK=4 App. B vector:
  - Drive w to all-zero one cycle after accept -> result is still 3925841d....
  - Hold out_ready=0 for 5 cycles -> out_valid and encrypted_msg stable; in_ready=0 throughout.
  - Release out_ready -> in_ready=1 the next cycle.
- Back-to-back issue: App. B then App. C vector with in_valid held high and out_ready=1 -> second accept exactly 12 cycles after the first; both ciphertexts correct and in order.
- Reset mid-operation: assert rst at round 5 -> out_valid never rises for that block; in_ready=1 and encrypted_msg=0 after reset; a following App. B block encrypts correctly.
- With AES_CIPHER_ITER_ABORT_EN: abort at round 3 -> IDLE next cycle, no out_valid, encrypted_msg unchanged; the next block is correct. Assert abort and rst together -> reset values.

Source files
------------

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES-128/192/256 encryption core, one cipher round per clock.
// Optional abort input is compiled in when AES_CIPHER_ITER_ABORT_EN is defined.
module aes_cipher_iter #(
  parameter  int NK = 4,
  localparam int NR = NK + 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          state_in,
  input  logic [128*(NR+1)-1:0] w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          encrypted_msg,
`ifdef AES_CIPHER_ITER_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy
);

  localparam int              RW       = $clog2(NR + 1);
  localparam logic [RW-1:0]   RND_ONE  = RW'(1);
  localparam logic [RW-1:0]   RND_LAST = RW'(NR);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box computed as GF(2^8) inverse (b^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (i != 0) inv = gmul(inv, b);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte i of the state sits at bits [8*(15-i) +: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+r)%4))) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c) +: 8];
      a1 = s[8*(14-4*c) +: 8];
      a2 = s[8*(13-4*c) +: 8];
      a3 = s[8*(12-4*c) +: 8];
      o[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  logic [1:0]              fsm;
  logic [RW-1:0]           rnd;
  logic [127:0]            state_reg;
  logic [127:0]            msg_reg;
  logic [128*(NR+1)-1:0]   key_reg;
  logic [127:0]            sb, sr, mc, ark_s, ark_k, round_out;
  logic                    abort_hit;

`ifdef AES_CIPHER_ITER_ABORT_EN
  assign abort_hit = abort && (fsm != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Single datapath; in IDLE the AddRoundKey stage is borrowed for the initial whitening.
  // NOTE: every signal written here is assigned on every path, so no latch is inferred.
  always_comb begin
    sb = sub_bytes(state_reg);
    sr = shift_rows(sb);
    mc = mix_columns(sr);
    if (fsm == IDLE) begin
      ark_s = state_in;
      ark_k = w[127:0];
    end else begin
      ark_s = (rnd == RND_LAST) ? sr : mc;
      ark_k = key_reg[128*int'(rnd) +: 128];
    end
    round_out = add_round_key(ark_s, ark_k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      rnd       <= '0;
      state_reg <= '0;
      msg_reg   <= '0;
    end else if (abort_hit) begin
      fsm <= IDLE;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          state_reg <= round_out;
          rnd       <= RND_ONE;
          fsm       <= ROUND;
        end
        ROUND: begin
          state_reg <= round_out;
          if (rnd == RND_LAST) begin
            msg_reg <= round_out;
            fsm     <= DONE;
          end else begin
            rnd <= rnd + RND_ONE;
          end
        end
        DONE: if (out_ready) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

  // NOTE: the key schedule register is wide pure data and is never read before an
  // accept loads it, so it deliberately has no reset.
  always_ff @(posedge clk) begin
    if (!rst && fsm == IDLE && in_valid) key_reg <= w;
  end

  assign in_ready      = (fsm == IDLE);
  assign busy          = (fsm == ROUND);
  assign out_valid     = (fsm == DONE);
  assign encrypted_msg = msg_reg;

endmodule
